// File: rtl/ps2_action_decoder.sv
// rtl/ps2_action_decoder.sv - PS/2 frame receiver and make/break decoder driving a 4-bit player action code.
// Optional parity enforcement: define PS2_PARITY_CHECK_EN.
module ps2_action_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] keyboard_input,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          strobe, data_bit;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par_bit, par_n;
  logic [TW-1:0] wd, wd_n;
  logic          deliver, err_n, parity_ok;

  logic          brk, brk_n, ext, ext_n;
  logic [3:0]    kin_n, act;
  logic          kv_n;

  // Synchronizers and glitch filter: the filtered level flips only after a full run of disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      filt_prev <= filt_clk;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign strobe    = filt_prev & ~filt_clk;
  assign data_bit  = data_sync[1];
  // With enforcement off the captured parity bit is masked out here.
  assign parity_ok = ~PARITY_EN | (^{shift, par_bit});

  function automatic logic [3:0] action_of(input logic [7:0] code);
    case (code)
      8'h1C:   action_of = 4'd1;
      8'h1B:   action_of = 4'd2;
      8'h23:   action_of = 4'd3;
      8'h1D:   action_of = 4'd4;
      8'h29:   action_of = 4'd5;
      default: action_of = 4'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shift          <= '0;
      par_bit        <= 1'b0;
      wd             <= '0;
      brk            <= 1'b0;
      ext            <= 1'b0;
      keyboard_input <= '0;
      key_valid      <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      state          <= state_n;
      bit_cnt        <= bit_cnt_n;
      shift          <= shift_n;
      par_bit        <= par_n;
      wd             <= wd_n;
      brk            <= brk_n;
      ext            <= ext_n;
      keyboard_input <= kin_n;
      key_valid      <= kv_n;
      frame_err      <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par_bit;
    wd_n      = '0;
    deliver   = 1'b0;
    err_n     = 1'b0;
    if (state != IDLE && !strobe) wd_n = wd + TW'(1);
    case (state)
      IDLE: begin
        if (strobe && !data_bit) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (strobe) begin
          shift_n   = {data_bit, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (strobe) begin
          par_n   = data_bit;
          state_n = STOP;
        end
      end
      STOP: begin
        if (strobe) begin
          state_n = IDLE;
          if (data_bit && parity_ok) deliver = 1'b1;
          else                       err_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // A stalled frame is abandoned; decoder flags survive so a pending F0/E0 still applies.
    if (state != IDLE && !strobe && wd == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      err_n   = 1'b1;
      wd_n    = '0;
    end
  end

  always_comb begin
    kin_n = keyboard_input;
    kv_n  = 1'b0;
    brk_n = brk;
    ext_n = ext;
    act   = action_of(shift);
    if (deliver) begin
      if (shift == 8'hF0) begin
        brk_n = 1'b1;
      end else if (shift == 8'hE0) begin
        ext_n = 1'b1;
      end else begin
        if (!ext && act != 4'd0) begin
          if (brk) begin
            if (act == keyboard_input) kin_n = 4'd0;
          end else if (act != keyboard_input) begin
            kin_n = act;
            kv_n  = 1'b1;
          end
        end
        brk_n = 1'b0;
        ext_n = 1'b0;
      end
    end
  end

endmodule
